// File: rtl/alu_arb_pkg.sv
// Shared definitions for the ALU arbiter slice: FSM state encoding and the
// ALU operation codes used by requesters and by the alu datapath.
package alu_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SLL = 4'b0100;
   localparam logic [3:0] ALU_SRL = 4'b0101;
   localparam logic [3:0] ALU_XOR = 4'b0110;
   localparam logic [3:0] ALU_SRA = 4'b0111;
   localparam logic [3:0] ALU_EQ  = 4'b1000;
   localparam logic [3:0] ALU_NE  = 4'b1001;
   localparam logic [3:0] ALU_LTU = 4'b1010;
   localparam logic [3:0] ALU_GEU = 4'b1011;
   localparam logic [3:0] ALU_SLT = 4'b1100;

endpackage

// File: rtl/alu.sv
// Combinational ALU.
//   SrcA, SrcB  : operands
//   Operation   : opcode (alu_arb_pkg ALU_* constants)
//   ALUResult   : result; compares return 0/1, unknown opcodes return 0
module alu
   import alu_arb_pkg::*;
#(
   parameter int DATA_WIDTH    = 32,
   parameter int OPCODE_LENGTH = 4
) (
   input  logic [DATA_WIDTH-1:0]    SrcA,
   input  logic [DATA_WIDTH-1:0]    SrcB,
   input  logic [OPCODE_LENGTH-1:0] Operation,
   output logic [DATA_WIDTH-1:0]    ALUResult
);

   localparam logic [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(1);

   always_comb begin
      ALUResult = '0;
      case (Operation)
         ALU_AND: ALUResult = SrcA & SrcB;
         ALU_OR:  ALUResult = SrcA | SrcB;
         ALU_ADD: ALUResult = SrcA + SrcB;
         // Shift amount is the whole SrcB: anything >= DATA_WIDTH flushes out.
         ALU_SLL: ALUResult = SrcA << SrcB;
         ALU_SRL: ALUResult = SrcA >> SrcB;
         ALU_XOR: ALUResult = SrcA ^ SrcB;
         ALU_SRA: ALUResult = DATA_WIDTH'($signed(SrcA) >>> SrcB);
         ALU_EQ:  ALUResult = (SrcA == SrcB) ? ONE : '0;
         ALU_NE:  ALUResult = (SrcA != SrcB) ? ONE : '0;
         ALU_LTU: ALUResult = (SrcA <  SrcB) ? ONE : '0;
         ALU_GEU: ALUResult = (SrcA >= SrcB) ? ONE : '0;
         ALU_SLT: ALUResult = ($signed(SrcA) < $signed(SrcB)) ? ONE : '0;
         default: ALUResult = '0;
      endcase
   end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin share of one ALU between NUM_REQ requesters.
//   clk, rst_n             : clock, async active-low reset
//   req_valid / req_ready  : per-requester request handshake (ready one-hot or 0)
//   req_srca/srcb/op       : packed per-requester operands and opcode
//   rsp_valid / rsp_ready  : single response handshake
//   rsp_id, rsp_result     : owner index and ALU result, held until accepted
//   busy                   : transaction in flight (state != IDLE)
// Flow: IDLE (grant + latch) -> EXEC (ALU evaluates) -> RESP (hold until taken).
module alu_arbiter
   import alu_arb_pkg::*;
#(
   parameter int DATA_WIDTH    = 32,
   parameter int OPCODE_LENGTH = 4,
   parameter int NUM_REQ       = 2,
   localparam int ID_W         = $clog2(NUM_REQ)
) (
   input  logic                                   clk,
   input  logic                                   rst_n,
   input  logic [NUM_REQ-1:0]                     req_valid,
   output logic [NUM_REQ-1:0]                     req_ready,
   input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]     req_srca,
   input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]     req_srcb,
   input  logic [NUM_REQ-1:0][OPCODE_LENGTH-1:0]  req_op,
   output logic                                   rsp_valid,
   input  logic                                   rsp_ready,
   output logic [ID_W-1:0]                        rsp_id,
   output logic [DATA_WIDTH-1:0]                  rsp_result,
   output logic                                   busy
);

   state_t                   state_q, state_d;
   logic [ID_W-1:0]          rr_ptr_q, rr_ptr_d;
   logic [DATA_WIDTH-1:0]    srca_q, srca_d;
   logic [DATA_WIDTH-1:0]    srcb_q, srcb_d;
   logic [OPCODE_LENGTH-1:0] op_q, op_d;
   logic [ID_W-1:0]          id_q, id_d;
   logic [DATA_WIDTH-1:0]    result_q, result_d;

   logic                     grant_found;
   logic [ID_W-1:0]          grant_idx;
   logic [DATA_WIDTH-1:0]    alu_result;

   // First valid requester at or after rr_ptr, wrapping. Modulo keeps this
   // correct for non-power-of-two NUM_REQ.
   always_comb begin
      int idx;
      idx         = 0;
      grant_found = 1'b0;
      grant_idx   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = (int'(rr_ptr_q) + i) % NUM_REQ;
         if (!grant_found && req_valid[idx]) begin
            grant_found = 1'b1;
            grant_idx   = ID_W'(idx);
         end
      end
   end

   always_comb begin
      req_ready = '0;
      if (state_q == IDLE && grant_found) req_ready[grant_idx] = 1'b1;
   end

   alu #(
      .DATA_WIDTH    (DATA_WIDTH),
      .OPCODE_LENGTH (OPCODE_LENGTH)
   ) u_alu (
      .SrcA      (srca_q),
      .SrcB      (srcb_q),
      .Operation (op_q),
      .ALUResult (alu_result)
   );

   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      srca_d   = srca_q;
      srcb_d   = srcb_q;
      op_d     = op_q;
      id_d     = id_q;
      result_d = result_q;
      case (state_q)
         IDLE: begin
            if (grant_found) begin
               srca_d   = req_srca[grant_idx];
               srcb_d   = req_srcb[grant_idx];
               op_d     = req_op[grant_idx];
               id_d     = grant_idx;
               rr_ptr_d = ID_W'((int'(grant_idx) + 1) % NUM_REQ);
               state_d  = EXEC;
            end
         end
         EXEC: begin
            result_d = alu_result;
            state_d  = RESP;
         end
         RESP: begin
            if (rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         rr_ptr_q <= '0;
         srca_q   <= '0;
         srcb_q   <= '0;
         op_q     <= '0;
         id_q     <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         srca_q   <= srca_d;
         srcb_q   <= srcb_d;
         op_q     <= op_d;
         id_q     <= id_d;
         result_q <= result_d;
      end
   end

   assign rsp_valid  = (state_q == RESP);
   assign rsp_id     = id_q;
   assign rsp_result = result_q;
   assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a response scoreboard: stimulus pushes
// the expected {id,result}; the monitor pops on every response handshake.
module tb_alu_arbiter;
   import alu_arb_pkg::*;

   localparam int DW = 32;
   localparam int OW = 4;
   localparam int NR = 2;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic [NR-1:0]         req_valid;
   logic [NR-1:0]         req_ready;
   logic [NR-1:0][DW-1:0] req_srca;
   logic [NR-1:0][DW-1:0] req_srcb;
   logic [NR-1:0][OW-1:0] req_op;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [0:0]            rsp_id;
   logic [DW-1:0]         rsp_result;
   logic                  busy;

   typedef struct packed {
      logic [0:0]    id;
      logic [DW-1:0] res;
   } exp_t;

   exp_t sb_q[$];
   int   checks   = 0;
   int   failures = 0;

   alu_arbiter #(.DATA_WIDTH(DW), .OPCODE_LENGTH(OW), .NUM_REQ(NR)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_srca   (req_srca),
      .req_srcb   (req_srcb),
      .req_op     (req_op),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_id     (rsp_id),
      .rsp_result (rsp_result),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: scoreboard pop on handshake, plus req_ready one-hot-or-zero.
   always @(negedge clk) begin
      if (rst_n) begin
         chk("req_ready_onehot0", {31'd0, $onehot0(req_ready)}, 32'd1);
         if (rsp_valid && rsp_ready) begin
            if (sb_q.size() == 0) begin
               chk("unexpected_rsp", 32'd1, 32'd0);
            end else begin
               exp_t e;
               e = sb_q.pop_front();
               chk("rsp_id", {31'd0, rsp_id}, {31'd0, e.id});
               chk("rsp_result", rsp_result, e.res);
            end
         end
      end
   end

   // One full transaction with rsp_ready=1, starting in IDLE after tick().
   task automatic txn(input int gid, input logic [DW-1:0] res, input bit drop);
      exp_t e;
      chk("grant", {30'd0, req_ready}, 32'd1 << gid);
      e.id  = 1'(gid);
      e.res = res;
      sb_q.push_back(e);
      tick();                       // accept edge
      if (drop) req_valid[gid] = 1'b0;
      chk("exec_ready_low", {30'd0, req_ready}, 32'd0);
      chk("exec_no_valid", {31'd0, rsp_valid}, 32'd0);
      tick();                       // EXEC -> RESP
      chk("resp_valid", {31'd0, rsp_valid}, 32'd1);
      tick();                       // handshake -> IDLE
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
      chk({tag, "_rsp_id"}, {31'd0, rsp_id}, 32'd0);
      chk({tag, "_rsp_result"}, rsp_result, 32'd0);
      chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
   endtask

   task automatic pulse_reset();
      #2 rst_n = 1'b0;
      #1;
      sb_q.delete();
      @(negedge clk);
      #1 rst_n = 1'b1;
      tick();
   endtask

   initial begin
      rst_n     = 1'b0;
      req_valid = '0;
      req_srca  = '0;
      req_srcb  = '0;
      req_op    = '0;
      rsp_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("por");
      chk("por_req_ready", {30'd0, req_ready}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // 1: single ADD from requester 0
      req_srca[0] = 32'd5; req_srcb[0] = 32'd7; req_op[0] = ALU_ADD;
      req_valid = 2'b01;
      #1;
      txn(0, 32'd12, 1'b1);

      // 2: restart with rr_ptr=0, both valid; requester 1 SLT then LTU
      pulse_reset();
      req_srca[0] = 32'h0000_00F0; req_srcb[0] = 32'h0000_00FF; req_op[0] = ALU_XOR;
      req_srca[1] = 32'hFFFF_FFFF; req_srcb[1] = 32'd1;         req_op[1] = ALU_SLT;
      req_valid = 2'b11;
      #1;
      txn(0, 32'h0000_000F, 1'b1);
      txn(1, 32'd1, 1'b1);
      req_op[1] = ALU_LTU;
      req_valid = 2'b10;
      #1;
      txn(1, 32'd0, 1'b1);

      // 3: both held valid, strict alternation starting at 0
      req_srca[0] = 32'd1;  req_srcb[0] = 32'd1;  req_op[0] = ALU_ADD;
      req_srca[1] = 32'h10; req_srcb[1] = 32'h01; req_op[1] = ALU_OR;
      req_valid = 2'b11;
      #1;
      for (int k = 0; k < 6; k++) begin
         if (k % 2 == 0) txn(0, 32'd2, 1'b0);
         else            txn(1, 32'h11, 1'b0);
      end
      req_valid = 2'b00;

      // 4: backpressure in RESP; requester 1 waits meanwhile
      rsp_ready   = 1'b0;
      req_srca[0] = 32'h8000_0000; req_srcb[0] = 32'd4; req_op[0] = ALU_SRA;
      req_srca[1] = 32'd1;         req_srcb[1] = 32'd33; req_op[1] = ALU_SLL;
      req_valid = 2'b01;
      #1;
      chk("bp_grant", {30'd0, req_ready}, 32'd1);
      begin
         exp_t e;
         e.id = 1'b0; e.res = 32'hF800_0000;
         sb_q.push_back(e);
      end
      tick();
      req_valid = 2'b10;
      tick();
      for (int k = 0; k < 5; k++) begin
         chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
         chk("bp_id", {31'd0, rsp_id}, 32'd0);
         chk("bp_result", rsp_result, 32'hF800_0000);
         chk("bp_req_ready", {30'd0, req_ready}, 32'd0);
         chk("bp_busy", {31'd0, busy}, 32'd1);
         tick();
      end
      rsp_ready = 1'b1;
      tick();
      txn(1, 32'd0, 1'b1);          // shift by 33 flushes everything

      // 5: undefined opcode yields zero
      req_srca[0] = 32'd9; req_srcb[0] = 32'd3; req_op[0] = 4'b0011;
      req_valid = 2'b01;
      #1;
      txn(0, 32'd0, 1'b1);

      // 6a: reset during EXEC (rr_ptr had moved to 1)
      req_srca[0] = 32'd5; req_srcb[0] = 32'd7; req_op[0] = ALU_ADD;
      req_valid = 2'b01;
      #1;
      chk("r6a_grant", {30'd0, req_ready}, 32'd1);
      tick();
      req_valid = 2'b00;
      chk("r6a_in_exec", {31'd0, busy}, 32'd1);
      #2 rst_n = 1'b0;
      #1 check_reset_outputs("rst_exec");
      sb_q.delete();
      @(negedge clk);
      #1 rst_n = 1'b1;
      tick();

      // 6b: reset during RESP, again after granting requester 0
      rsp_ready = 1'b0;
      req_valid = 2'b01;
      #1;
      chk("r6b_grant", {30'd0, req_ready}, 32'd1);
      tick();
      req_valid = 2'b00;
      tick();
      chk("r6b_in_resp", {31'd0, rsp_valid}, 32'd1);
      chk("r6b_result", rsp_result, 32'd12);
      #2 rst_n = 1'b0;
      #1 check_reset_outputs("rst_resp");
      sb_q.delete();
      @(negedge clk);
      #1 rst_n = 1'b1;
      rsp_ready = 1'b1;
      tick();

      // After reset, rr_ptr=0 so requester 0 wins a simultaneous request
      req_srca[1] = 32'd3; req_srcb[1] = 32'd3; req_op[1] = ALU_EQ;
      req_valid = 2'b11;
      #1;
      txn(0, 32'd12, 1'b1);
      txn(1, 32'd1, 1'b1);
      req_valid = 2'b00;

      repeat (3) tick();
      chk("sb_drained", sb_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Safety net: the run is short; exceeding this means something hung.
   initial begin
      #100000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule
